// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: CRC-32 check, FCS strip and length check on the RX path.
// Define ETH_RX_FCS_STATS_EN to add saturating good_cnt/bad_cnt outputs.
module eth_rx_fcs_check #(
  parameter int DATA_W        = 8,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_W         = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [1:0]        in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_fcs_err,
  output logic              out_len_err,
  output logic              out_hdr_err,
  output logic              out_abort,
  output logic              out_drop
`ifdef ETH_RX_FCS_STATS_EN
  ,
  output logic [31:0]       good_cnt,
  output logic [31:0]       bad_cnt
`endif
);

  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_RES  = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_FRAME_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] LEN_OVR  = LEN_W'(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_FILL = LEN_W'(4);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DISCARD} state_t;

  state_t                   state, state_nx;
  logic [31:0]              crc, crc_nx;
  logic [LEN_W-1:0]         cnt, cnt_nx;
  logic [3:0][DATA_W-1:0]   hold, hold_nx;
  logic                     emit, first, fin, over;
  logic                     abort, drop;

  function automatic logic [31:0] crc_step(
    input logic [31:0]       c,
    input logic [DATA_W-1:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_nx = state;
    crc_nx   = crc;
    cnt_nx   = cnt;
    hold_nx  = hold;
    emit     = 1'b0;
    first    = 1'b0;
    abort    = 1'b0;
    drop     = 1'b0;
    if (in_valid && (in_sof || state != IDLE)) begin
      hold_nx = {hold[2:0], in_data};
      if (in_sof) begin
        crc_nx   = crc_step(CRC_INIT, in_data);
        cnt_nx   = LEN_W'(1);
        state_nx = FILL;
        abort    = (state == STREAM);
      end else begin
        crc_nx = crc_step(crc, in_data);
        cnt_nx = (&cnt) ? cnt : cnt + 1'b1;
        unique case (state)
          FILL: begin
            if (cnt == LEN_FILL) begin
              emit     = 1'b1;
              first    = 1'b1;
              state_nx = STREAM;
            end
          end
          STREAM: begin
            emit = 1'b1;
            if (cnt_nx == LEN_OVR) state_nx = DISCARD;
          end
          default: ;
        endcase
      end
      if (in_eof) begin
        state_nx = IDLE;
        drop     = in_sof || (state == FILL && !emit);
      end
    end
  end

  // An over-length frame is closed early; its CRC is never judged.
  assign over = cnt_nx > LEN_MAX;
  assign fin  = emit && (in_eof || state_nx == DISCARD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      crc         <= CRC_INIT;
      cnt         <= '0;
      hold        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_fcs_err <= 1'b0;
      out_len_err <= 1'b0;
      out_hdr_err <= 1'b0;
      out_abort   <= 1'b0;
      out_drop    <= 1'b0;
    end else begin
      state       <= state_nx;
      crc         <= crc_nx;
      cnt         <= cnt_nx;
      hold        <= hold_nx;
      out_valid   <= emit;
      out_data    <= emit ? hold[3] : '0;
      out_sof     <= first;
      out_eof     <= fin;
      out_fcs_err <= fin && !over && (crc_nx != CRC_RES);
      out_len_err <= fin && (over || cnt_nx < LEN_MIN);
      out_hdr_err <= fin && in_eof && (|in_err);
      out_abort   <= abort;
      out_drop    <= drop;
    end
  end

`ifdef ETH_RX_FCS_STATS_EN
  logic bad_evt;
  assign bad_evt = out_abort || out_drop ||
                   (out_eof && (out_fcs_err || out_len_err || out_hdr_err));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (out_eof && !bad_evt && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
      if (bad_evt && bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: directed scenarios for eth_rx_fcs_check.
// Output bytes are captured on the falling edge and checked per scenario.
module tb_eth_rx_fcs_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_sof = 1'b0;
  logic       in_eof = 1'b0;
  logic [1:0] in_err = '0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof, out_eof;
  logic       out_fcs_err, out_len_err, out_hdr_err;
  logic       out_abort, out_drop;
`ifdef ETH_RX_FCS_STATS_EN
  logic [31:0] good_cnt, bad_cnt;
`endif

  eth_rx_fcs_check dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .in_eof      (in_eof),
    .in_err      (in_err),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_fcs_err (out_fcs_err),
    .out_len_err (out_len_err),
    .out_hdr_err (out_hdr_err),
    .out_abort   (out_abort),
    .out_drop    (out_drop)
`ifdef ETH_RX_FCS_STATS_EN
    ,
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sof, eof, fcs, len, hdr;
    int         cyc;
  } rec_t;

  rec_t       q[$];
  logic [7:0] frm [0:2047];
  int         cyc = 0;
  int         eof_cyc = 0;
  int         n_abort = 0, n_drop = 0, n_stray = 0;
  int         n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid)
      q.push_back('{d: out_data, sof: out_sof, eof: out_eof,
                    fcs: out_fcs_err, len: out_len_err,
                    hdr: out_hdr_err, cyc: cyc});
    if (out_abort) n_abort++;
    if (out_drop) n_drop++;
    if (!out_eof && (out_fcs_err || out_len_err || out_hdr_err)) n_stray++;
    if ((out_abort || out_drop) && out_valid) n_stray++;
  end

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] pat(input int i, input int seed);
    return 8'(i * 7 + seed * 13 + 1);
  endfunction

  // n_total bytes: pattern data followed by a correct FCS, LSB first
  task automatic build(input int n_total, input int seed);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n_total - 4; i++) begin
      frm[i] = pat(i, seed);
      c = crc8(c, frm[i]);
    end
    c = ~c;
    frm[n_total-4] = c[7:0];
    frm[n_total-3] = c[15:8];
    frm[n_total-2] = c[23:16];
    frm[n_total-1] = c[31:24];
  endtask

  task automatic send(input int first, input int last, input bit sof,
                      input bit eof, input logic [1:0] err, input bit gaps);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frm[i];
      in_sof   = sof && (i == first);
      in_eof   = eof && (i == last);
      in_err   = (i == last) ? err : 2'b00;
      if (in_eof) eof_cyc = cyc + 1;
      if (gaps && (i % 7 == 3) && i != last) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_sof   = 1'b0;
          in_eof   = 1'b0;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    in_err   = 2'b00;
  endtask

  task automatic flush();
    repeat (6) @(negedge clk);
    #1;
  endtask

  function automatic int data_errs(input int qoff, input int foff, input int n);
    int e;
    e = 0;
    for (int i = 0; i < n; i++) begin
      if (qoff + i >= q.size()) e++;
      else if (q[qoff+i].d !== frm[foff+i]) e++;
    end
    return e;
  endfunction

  function automatic int eof_total();
    int n;
    n = 0;
    foreach (q[i]) if (q[i].eof) n++;
    return n;
  endfunction

  function automatic logic [15:0] all_out();
    return {out_valid, out_data, out_sof, out_eof, out_fcs_err,
            out_len_err, out_hdr_err, out_abort, out_drop};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (all_out() !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_hold outputs=%h required=0", all_out());
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (all_out() !== 16'h0 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_idle outputs=%h bytes=%0d required=0/0", all_out(), q.size());
    end
  endtask

  task automatic test_good_frame();
    int a0, d0, e;
    q.delete();
    a0 = n_abort;
    d0 = n_drop;
    build(64, 3);
    send(0, 63, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    n_tests++;
    if (q.size() !== 60) begin
      n_fail++;
      $display("FAIL good_count got=%0d required=60", q.size());
    end
    e = data_errs(0, 0, 60);
    n_tests++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL good_data mismatched=%0d required=0", e);
    end
    n_tests++;
    if (q[0].sof !== 1'b1 || q[59].eof !== 1'b1 || eof_total() !== 1) begin
      n_fail++;
      $display("FAIL good_markers sof=%b eof=%b eofs=%0d required=1/1/1",
               q[0].sof, q[59].eof, eof_total());
    end
    n_tests++;
    if ({q[59].fcs, q[59].len, q[59].hdr} !== 3'b000) begin
      n_fail++;
      $display("FAIL good_status got=%b%b%b required=000", q[59].fcs, q[59].len, q[59].hdr);
    end
    n_tests++;
    if (q[59].cyc !== eof_cyc) begin
      n_fail++;
      $display("FAIL good_latency eof_cycle=%0d required=%0d", q[59].cyc, eof_cyc);
    end
    n_tests++;
    if (n_abort - a0 !== 0 || n_drop - d0 !== 0) begin
      n_fail++;
      $display("FAIL good_pulses abort=%0d drop=%0d required=0/0", n_abort - a0, n_drop - d0);
    end
  endtask

  task automatic test_fcs_error();
    int e;
    q.delete();
    build(64, 3);
    frm[20] = frm[20] ^ 8'h01;
    send(0, 63, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    e = data_errs(0, 0, 60);
    n_tests++;
    if (q.size() !== 60 || e !== 0) begin
      n_fail++;
      $display("FAIL fcs_bytes count=%0d mismatched=%0d required=60/0", q.size(), e);
    end
    n_tests++;
    if ({q[59].eof, q[59].fcs, q[59].len, q[59].hdr} !== 4'b1100) begin
      n_fail++;
      $display("FAIL fcs_status eof,fcs,len,hdr=%b%b%b%b required=1100",
               q[59].eof, q[59].fcs, q[59].len, q[59].hdr);
    end
  endtask

  // "123456789" has CRC-32 0xCBF43926; sent LSB first as its FCS
  task automatic test_known_vector();
    int e;
    q.delete();
    for (int i = 0; i < 9; i++) frm[i] = 8'(8'h31 + i);
    frm[9]  = 8'h26;
    frm[10] = 8'h39;
    frm[11] = 8'hF4;
    frm[12] = 8'hCB;
    send(0, 12, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    e = data_errs(0, 0, 9);
    n_tests++;
    if (q.size() !== 9 || e !== 0) begin
      n_fail++;
      $display("FAIL kv_bytes count=%0d mismatched=%0d required=9/0", q.size(), e);
    end
    n_tests++;
    if ({q[8].eof, q[8].fcs, q[8].len} !== 3'b101) begin
      n_fail++;
      $display("FAIL kv_status eof,fcs,len=%b%b%b required=101", q[8].eof, q[8].fcs, q[8].len);
    end
  endtask

  task automatic test_short_frames();
    int d0;
    q.delete();
    d0 = n_drop;
    build(64, 7);
    send(0, 0, 1'b1, 1'b1, 2'b00, 1'b0);
    send(0, 2, 1'b1, 1'b1, 2'b00, 1'b0);
    build(4, 7);
    send(0, 3, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    n_tests++;
    if (n_drop - d0 !== 3 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL short_drop drops=%0d bytes=%0d required=3/0", n_drop - d0, q.size());
    end
    build(5, 7);
    send(0, 4, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    n_tests++;
    if (q.size() !== 1 || q[0].d !== frm[0] || n_drop - d0 !== 3) begin
      n_fail++;
      $display("FAIL five_byte count=%0d data=%h drops=%0d required=1/%h/3",
               q.size(), q[0].d, n_drop - d0, frm[0]);
    end
    n_tests++;
    if ({q[0].sof, q[0].eof, q[0].fcs, q[0].len} !== 4'b1101) begin
      n_fail++;
      $display("FAIL five_status sof,eof,fcs,len=%b%b%b%b required=1101",
               q[0].sof, q[0].eof, q[0].fcs, q[0].len);
    end
  endtask

  task automatic test_restart();
    int a0, d0, e, s0;
    q.delete();
    a0 = n_abort;
    d0 = n_drop;
    s0 = n_stray;
    build(3, 2);
    frm[0] = 8'hA1;
    frm[1] = 8'hA2;
    frm[2] = 8'hA3;
    send(0, 2, 1'b1, 1'b1, 2'b00, 1'b0);
    build(64, 11);
    send(0, 29, 1'b1, 1'b0, 2'b00, 1'b0);
    build(64, 5);
    send(0, 63, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    n_tests++;
    if (n_drop - d0 !== 1 || n_abort - a0 !== 1) begin
      n_fail++;
      $display("FAIL restart_pulses drop=%0d abort=%0d required=1/1", n_drop - d0, n_abort - a0);
    end
    e = 0;
    for (int i = 0; i < 26; i++) if (q[i].d !== pat(i, 11)) e++;
    e += data_errs(26, 0, 60);
    n_tests++;
    if (q.size() !== 86 || e !== 0) begin
      n_fail++;
      $display("FAIL restart_bytes count=%0d mismatched=%0d required=86/0", q.size(), e);
    end
    n_tests++;
    if (q[0].sof !== 1'b1 || q[26].sof !== 1'b1 || eof_total() !== 1 ||
        {q[85].eof, q[85].fcs, q[85].len} !== 3'b100) begin
      n_fail++;
      $display("FAIL restart_markers sof0=%b sof26=%b eofs=%0d last=%b%b%b required=1/1/1/100",
               q[0].sof, q[26].sof, eof_total(), q[85].eof, q[85].fcs, q[85].len);
    end
    n_tests++;
    if (n_stray - s0 !== 0) begin
      n_fail++;
      $display("FAIL restart_stray got=%0d required=0", n_stray - s0);
    end
  endtask

  task automatic test_gaps_hdr();
    int e;
    q.delete();
    build(64, 9);
    send(0, 63, 1'b1, 1'b1, 2'b01, 1'b1);
    flush();
    e = data_errs(0, 0, 60);
    n_tests++;
    if (q.size() !== 60 || e !== 0) begin
      n_fail++;
      $display("FAIL gaps_bytes count=%0d mismatched=%0d required=60/0", q.size(), e);
    end
    n_tests++;
    if ({q[59].eof, q[59].fcs, q[59].len, q[59].hdr} !== 4'b1001) begin
      n_fail++;
      $display("FAIL gaps_status eof,fcs,len,hdr=%b%b%b%b required=1001",
               q[59].eof, q[59].fcs, q[59].len, q[59].hdr);
    end
  endtask

  task automatic test_over_length();
    int e, s0;
    s0 = n_stray;
    q.delete();
    build(1518, 4);
    send(0, 1517, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    e = data_errs(0, 0, 1514);
    n_tests++;
    if (q.size() !== 1514 || e !== 0 ||
        {q[1513].eof, q[1513].fcs, q[1513].len} !== 3'b100) begin
      n_fail++;
      $display("FAIL max_len count=%0d mismatched=%0d last=%b%b%b required=1514/0/100",
               q.size(), e, q[1513].eof, q[1513].fcs, q[1513].len);
    end
    q.delete();
    build(1519, 6);
    send(0, 1518, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    n_tests++;
    if (q.size() !== 1515 || {q[1514].eof, q[1514].fcs, q[1514].len} !== 3'b101) begin
      n_fail++;
      $display("FAIL over_1519 count=%0d last=%b%b%b required=1515/101",
               q.size(), q[1514].eof, q[1514].fcs, q[1514].len);
    end
    q.delete();
    build(1525, 8);
    send(0, 1524, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    e = data_errs(0, 0, 1515);
    n_tests++;
    if (q.size() !== 1515 || e !== 0 || eof_total() !== 1 ||
        {q[1514].eof, q[1514].fcs, q[1514].len} !== 3'b101) begin
      n_fail++;
      $display("FAIL over_1525 count=%0d mismatched=%0d eofs=%0d last=%b%b%b required=1515/0/1/101",
               q.size(), e, eof_total(), q[1514].eof, q[1514].fcs, q[1514].len);
    end
    n_tests++;
    if (n_stray - s0 !== 0) begin
      n_fail++;
      $display("FAIL over_stray got=%0d required=0", n_stray - s0);
    end
  endtask

  task automatic test_reset_mid();
    int a0, e;
    a0 = n_abort;
    build(64, 13);
    send(0, 39, 1'b1, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    #1;
    n_tests++;
    if (all_out() !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid outputs=%h required=0", all_out());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    q.delete();
    build(64, 17);
    send(0, 63, 1'b1, 1'b1, 2'b00, 1'b0);
    flush();
    e = data_errs(0, 0, 60);
    n_tests++;
    if (q.size() !== 60 || e !== 0 || n_abort - a0 !== 0) begin
      n_fail++;
      $display("FAIL rst_next count=%0d mismatched=%0d aborts=%0d required=60/0/0",
               q.size(), e, n_abort - a0);
    end
    n_tests++;
    if ({q[59].eof, q[59].fcs, q[59].len, q[59].hdr} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_next_status eof,fcs,len,hdr=%b%b%b%b required=1000",
               q[59].eof, q[59].fcs, q[59].len, q[59].hdr);
    end
`ifdef ETH_RX_FCS_STATS_EN
    n_tests++;
    if (good_cnt !== 32'd1 || bad_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats good=%0d bad=%0d required=1/0", good_cnt, bad_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_fcs_error();
    test_known_vector();
    test_short_frames();
    test_restart();
    test_gaps_hdr();
    test_over_length();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
